// File: rtl/countdown_alert.sv
// countdown_alert: MM:SS countdown alarm timer driving four 7-segment digits.
// Buttons load minutes/seconds and start/pause the count. Reaching 00:00
// raises a blinking alarm, which ends on any button press or after
// ALARM_TICKS one-second ticks.
module countdown_alert #(
  parameter int TICK_DIV    = 50000000,
  parameter int ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic [3:0] KEY,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       alarm,
  output logic [3:0] ledr,
  output logic       running
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    S_SET   = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  logic rst_n;
  assign rst_n = KEY[0];

  // Active-low 7-segment encoding of a single decimal digit.
  function automatic logic [6:0] seg7(input logic [5:0] d);
    case (d)
      6'd0:    seg7 = 7'b1000000;
      6'd1:    seg7 = 7'b1111001;
      6'd2:    seg7 = 7'b0100100;
      6'd3:    seg7 = 7'b0110000;
      6'd4:    seg7 = 7'b0011001;
      6'd5:    seg7 = 7'b0010010;
      6'd6:    seg7 = 7'b0000010;
      6'd7:    seg7 = 7'b1111000;
      6'd8:    seg7 = 7'b0000000;
      6'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Index 0 = start/pause/ack, 1 = minute+1, 2 = second+1.
  logic [2:0] key_p0, key_p1, key_p2;
  logic [2:0] press;

  state_t          state_q, state_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic            blink_q, blink_d;
  logic            tick;

  // Button synchronizer stage p0/p1 plus delay stage p2; reset to the
  // released level so reset never manufactures a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 3'b111;
      key_p1 <= 3'b111;
      key_p2 <= 3'b111;
    end else begin
      key_p0 <= KEY[3:1];
      key_p1 <= key_p0;
      key_p2 <= key_p1;
    end
  end

  // A press is the synchronized 1->0 transition, one cycle long.
  assign press = key_p2 & ~key_p1;

  // State, time, tick and alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SET;
      min_q   <= '0;
      sec_q   <= '0;
      tcnt_q  <= '0;
      acnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tcnt_q  <= tcnt_d;
      acnt_q  <= acnt_d;
      blink_q <= blink_d;
    end
  end

  // Next-state logic: edits in SET, countdown in RUN, alarm timing in ALARM.
  // A button press always takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tcnt_d  = tcnt_q;
    acnt_d  = acnt_q;
    blink_d = blink_q;
    tick    = 1'b0;

    if (state_q == S_RUN || state_q == S_ALARM) begin
      tick   = (tcnt_q == TICK_LAST);
      tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    end

    case (state_q)
      S_SET: begin
        if (press[1]) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        if (press[2]) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        if (press[0] && (min_q != 6'd0 || sec_q != 6'd0)) begin
          state_d = S_RUN;
          tcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (press[0]) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
          end else begin
            min_d = min_q - 6'd1;
            sec_d = 6'd59;
          end
          if (min_q == 6'd0 && sec_q == 6'd1) begin
            state_d = S_ALARM;
            blink_d = 1'b1;
            acnt_d  = '0;
          end
        end
      end
      S_PAUSE: begin
        if (press[0]) state_d = S_RUN;
      end
      S_ALARM: begin
        if (press != 3'b000) begin
          state_d = S_SET;
          blink_d = 1'b0;
          acnt_d  = '0;
        end else if (tick) begin
          if (acnt_q == ALARM_LAST) begin
            state_d = S_SET;
            blink_d = 1'b0;
            acnt_d  = '0;
          end else begin
            blink_d = ~blink_q;
            acnt_d  = acnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_SET;
    endcase
  end

  // Registered digit stage: hex follows the time registers by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex0 <= 7'b1000000;
      hex1 <= 7'b1000000;
      hex2 <= 7'b1000000;
      hex3 <= 7'b1000000;
    end else begin
      hex0 <= seg7(sec_q % 6'd10);
      hex1 <= seg7(sec_q / 6'd10);
      hex2 <= seg7(min_q % 6'd10);
      hex3 <= seg7(min_q / 6'd10);
    end
  end

  assign alarm   = (state_q == S_ALARM);
  assign running = (state_q == S_RUN);
  assign ledr    = {4{blink_q}};

endmodule

// File: tb/tb_countdown_alert.sv
// tb_countdown_alert: scenario tasks for countdown_alert with randomized
// countdown lengths checked against an arithmetic model of the timer.
module tb_countdown_alert;

  localparam int TD = 4;
  localparam int AT = 6;

  logic       clk = 1'b0;
  logic [3:0] KEY = 4'b1111;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       alarm, running;
  logic [3:0] ledr;
  logic [27:0] disp;
  int n_checks = 0;
  int n_pass   = 0;

  countdown_alert #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clk(clk), .KEY(KEY), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .alarm(alarm), .ledr(ledr), .running(running)
  );

  always #5 clk = ~clk;
  assign disp = {hex3, hex2, hex1, hex0};

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected four-digit display for a remaining time in seconds.
  function automatic logic [27:0] exp_disp(input int total);
    int m, s;
    m = total / 60;
    s = total % 60;
    return {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Button low for exactly one sampling edge; the action lands two edges later.
  task automatic kick(input int b);
    KEY[b] = 1'b0;
    cyc(1);
    KEY[b] = 1'b1;
  endtask

  // Full press: returns after the display has caught up.
  task automatic press(input int b);
    kick(b);
    cyc(3);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    KEY = 4'b1110;
    #2;
    KEY = 4'b1111;
    cyc(2);
  endtask

  task automatic set_time(input int m, input int s);
    repeat (m) press(2);
    repeat (s) press(3);
  endtask

  // Start from SET with t seconds loaded, then compare every cycle against
  // the expected countdown, alarm blink and auto-clear.
  task automatic run_check(input int t);
    int rem, tt, last;
    logic [3:0] exp_ledr;
    logic exp_al, exp_run;
    kick(1);
    cyc(1);
    n_checks++;
    if (running !== 1'b0) $display("FAIL start_edge2 running=%b want 0", running);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (running !== 1'b1) $display("FAIL start_edge3 running=%b want 1", running);
    else n_pass++;
    last = TD * t + TD * AT + 2;
    for (int k = 1; k <= last; k++) begin
      cyc(1);
      exp_run = (k < TD * t);
      exp_al  = (k >= TD * t) && (k < TD * t + TD * AT);
      tt = k - TD * t;
      exp_ledr = (exp_al && ((tt / TD) % 2 == 0)) ? 4'hf : 4'h0;
      rem = t - (k - 1) / TD;
      if (rem < 0) rem = 0;
      n_checks++;
      if ({running, alarm, ledr, disp} !== {exp_run, exp_al, exp_ledr, exp_disp(rem)})
        $display("FAIL countdown t=%0d k=%0d got run=%b al=%b ledr=%h disp=%h want run=%b al=%b ledr=%h disp=%h",
                 t, k, running, alarm, ledr, disp, exp_run, exp_al, exp_ledr, exp_disp(rem));
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    KEY = 4'b1111;
    #2;
    KEY = 4'b1110;
    #2;
    n_checks++;
    if ({disp, alarm, running, ledr} !== {exp_disp(0), 1'b0, 1'b0, 4'h0})
      $display("FAIL reset_state got disp=%h al=%b run=%b ledr=%h want disp=%h 0 0 0",
               disp, alarm, running, ledr, exp_disp(0));
    else n_pass++;
    KEY = 4'b1111;
    cyc(3);
    n_checks++;
    if ({disp, running} !== {exp_disp(0), 1'b0})
      $display("FAIL reset_release got disp=%h run=%b want disp=%h run=0", disp, running, exp_disp(0));
    else n_pass++;
  endtask

  task automatic test_set_wrap;
    int r;
    do_reset();
    repeat (60) press(2);
    n_checks++;
    if ({hex3, hex2} !== {7'b1000000, 7'b1000000})
      $display("FAIL min_wrap got %b %b want 1000000 1000000", hex3, hex2);
    else n_pass++;
    r = $urandom_range(1, 10);
    repeat (r) press(2);
    repeat (59) press(3);
    n_checks++;
    if ({hex1, hex0} !== {7'b0010010, 7'b0010000})
      $display("FAIL sec_59 got %b %b want 0010010 0010000", hex1, hex0);
    else n_pass++;
    n_checks++;
    if (disp !== exp_disp(r * 60 + 59)) $display("FAIL set_r59 got %h want %h", disp, exp_disp(r * 60 + 59));
    else n_pass++;
    press(3);
    n_checks++;
    if (disp !== exp_disp(r * 60)) $display("FAIL sec_wrap got %h want %h", disp, exp_disp(r * 60));
    else n_pass++;
  endtask

  task automatic test_borrow;
    do_reset();
    set_time(1, 0);
    kick(1);
    cyc(2);
    n_checks++;
    if (running !== 1'b1) $display("FAIL borrow_run running=%b want 1", running);
    else n_pass++;
    cyc(4);
    n_checks++;
    if (disp !== exp_disp(60)) $display("FAIL borrow_hold got %h want %h", disp, exp_disp(60));
    else n_pass++;
    cyc(1);
    n_checks++;
    if (disp !== exp_disp(59)) $display("FAIL borrow_59 got %h want %h", disp, exp_disp(59));
    else n_pass++;
    cyc(4);
    n_checks++;
    if (disp !== exp_disp(58)) $display("FAIL borrow_58 got %h want %h", disp, exp_disp(58));
    else n_pass++;
  endtask

  task automatic test_alarm;
    do_reset();
    set_time(0, 2);
    run_check(2);
  endtask

  task automatic test_pause_collision;
    int p;
    p = $urandom_range(2, 3);
    do_reset();
    set_time(0, 3);
    kick(1);
    cyc(p - 1);
    kick(1);
    cyc(2);
    n_checks++;
    if ({running, disp} !== {1'b0, exp_disp(3)})
      $display("FAIL pause_enter p=%0d got run=%b disp=%h want 0 %h", p, running, disp, exp_disp(3));
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      n_checks++;
      if ({running, disp} !== {1'b0, exp_disp(3)})
        $display("FAIL pause_frozen i=%0d got run=%b disp=%h want 0 %h", i, running, disp, exp_disp(3));
      else n_pass++;
    end
    kick(1);
    cyc(2);
    n_checks++;
    if (running !== 1'b1) $display("FAIL resume running=%b want 1", running);
    else n_pass++;
    cyc(TD - p);
    n_checks++;
    if (disp !== exp_disp(3)) $display("FAIL resume_hold p=%0d got %h want %h", p, disp, exp_disp(3));
    else n_pass++;
    cyc(1);
    n_checks++;
    if (disp !== exp_disp(2)) $display("FAIL resume_dec p=%0d got %h want %h", p, disp, exp_disp(2));
    else n_pass++;
    cyc(4);
    n_checks++;
    if (disp !== exp_disp(1)) $display("FAIL run_to_01 got %h want %h", disp, exp_disp(1));
    else n_pass++;
    kick(1);
    cyc(2);
    n_checks++;
    if ({running, alarm} !== 2'b00) $display("FAIL collide_state got run=%b al=%b want 0 0", running, alarm);
    else n_pass++;
    cyc(20);
    n_checks++;
    if ({running, alarm, disp} !== {2'b00, exp_disp(1)})
      $display("FAIL collide_hold got run=%b al=%b disp=%h want 0 0 %h", running, alarm, disp, exp_disp(1));
    else n_pass++;
  endtask

  task automatic test_ack;
    kick(1);
    cyc(2);
    n_checks++;
    if (running !== 1'b1) $display("FAIL ack_resume running=%b want 1", running);
    else n_pass++;
    for (int i = 0; i < 40 && alarm !== 1'b1; i++) cyc(1);
    n_checks++;
    if (alarm !== 1'b1) $display("FAIL ack_alarm_wait alarm=%b want 1 within 40 cycles", alarm);
    else n_pass++;
    kick(3);
    cyc(2);
    n_checks++;
    if ({alarm, running, ledr} !== 6'b0) $display("FAIL ack_clear got al=%b run=%b ledr=%h want 0 0 0", alarm, running, ledr);
    else n_pass++;
    cyc(10);
    n_checks++;
    if (disp !== exp_disp(0)) $display("FAIL ack_no_edit got %h want %h", disp, exp_disp(0));
    else n_pass++;
  endtask

  task automatic test_start_guard;
    do_reset();
    kick(1);
    cyc(2);
    n_checks++;
    if (running !== 1'b0) $display("FAIL guard_run running=%b want 0", running);
    else n_pass++;
    cyc(10);
    n_checks++;
    if ({running, alarm, disp} !== {2'b00, exp_disp(0)})
      $display("FAIL guard_hold got run=%b al=%b disp=%h want 0 0 %h", running, alarm, disp, exp_disp(0));
    else n_pass++;
  endtask

  task automatic test_random_countdown;
    int m, s;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      m = $urandom_range(0, 1);
      s = $urandom_range(0, 59);
      if (m == 0 && s == 0) s = 1;
      set_time(m, s);
      n_checks++;
      if (disp !== exp_disp(m * 60 + s)) $display("FAIL rand_set got %h want %h", disp, exp_disp(m * 60 + s));
      else n_pass++;
      run_check(m * 60 + s);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    set_time(12, 34);
    kick(1);
    cyc(8);
    n_checks++;
    if (running !== 1'b1) $display("FAIL async_pre running=%b want 1", running);
    else n_pass++;
    #2;
    KEY[0] = 1'b0;
    #1;
    n_checks++;
    if ({disp, alarm, running, ledr} !== {exp_disp(0), 1'b0, 1'b0, 4'h0})
      $display("FAIL async_reset got disp=%h al=%b run=%b ledr=%h want %h 0 0 0",
               disp, alarm, running, ledr, exp_disp(0));
    else n_pass++;
    @(posedge clk);
    #1;
    KEY[0] = 1'b1;
    cyc(6);
    n_checks++;
    if ({running, disp} !== {1'b0, exp_disp(0)})
      $display("FAIL async_after got run=%b disp=%h want 0 %h", running, disp, exp_disp(0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_set_wrap();
    test_borrow();
    test_alarm();
    test_pause_collision();
    test_ack();
    test_start_guard();
    test_random_countdown();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
